i2c_ioexp_target: RTL and testbench

- I2C responder (target) that emulates the output-relevant register subset of a PCAL6416A I/O expander.
- Lets an FPGA-side or bench I2C initiator, including the team's own expander controller, drive on-chip 16-bit output/config registers over the same wire protocol.
- Sits between the board I2C pins (open-drain SDA via sda_oe_n) and fabric logic consuming out_port/cfg_port; returns in_port on reads.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_filter.sv | 35 +++
 rtl/i2c_ioexp_target.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_ioexp_target.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target protocol states and expander register addresses.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } i2c_state_t;

  localparam logic [7:0] REG_IN0  = 8'h00;
  localparam logic [7:0] REG_IN1  = 8'h01;
  localparam logic [7:0] REG_OUT0 = 8'h02;
  localparam logic [7:0] REG_OUT1 = 8'h03;
  localparam logic [7:0] REG_CFG0 = 8'h06;
  localparam logic [7:0] REG_CFG1 = 8'h07;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one I2C line.
module i2c_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  logic [1:0] sync;
  logic [3:0] cnt;

  // Accept a new level only after FILT_LEN consecutive synchronized samples disagree with it
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= 4'd0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] != level) begin
        if (cnt == 4'(FILT_LEN - 1)) begin
          level <= sync[1];
          cnt   <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/i2c_ioexp_target.sv
// I2C target emulating the output/config register subset of a PCAL6416A expander.
module i2c_ioexp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h20,
  parameter int          FILT_LEN = 4,
  parameter logic [15:0] OUT_RST  = 16'h0000,
  parameter logic [15:0] CFG_RST  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe_n,
  input  logic [15:0] in_port,
  output logic [15:0] out_port,
  output logic [15:0] cfg_port,
  output logic        update,
  output logic        busy
);

  logic        scl_f, sda_f, scl_p1, sda_p1;
  logic        scl_rise, scl_fall, start, stop;
  i2c_state_t  state, state_nx;
  logic [2:0]  bit_cnt, bit_nx;
  logic        phase, phase_nx, rw, rw_nx, wr_flag, wr_nx;
  logic [6:0]  sh, sh_nx, tx, tx_nx;
  logic [7:0]  ptr, ptr_nx, rx, rd_byte;
  logic [15:0] out_nx, cfg_nx;
  logic        oe_nx, busy_nx, update_nx;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .raw(scl_in), .level(scl_f)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .raw(sda_in), .level(sda_f)
  );

  // Delay filtered levels one cycle so edges and bus conditions become single-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p1 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p1 <= scl_f;
      sda_p1 <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_p1;
  assign scl_fall = ~scl_f & scl_p1;
  assign start    = scl_f & scl_p1 & sda_p1 & ~sda_f;
  assign stop     = scl_f & scl_p1 & ~sda_p1 & sda_f;
  assign rx       = {sh, sda_f};

  // Read mux: unmapped pointers read back as zero
  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      REG_IN0:  rd_byte = in_port[7:0];
      REG_IN1:  rd_byte = in_port[15:8];
      REG_OUT0: rd_byte = out_port[7:0];
      REG_OUT1: rd_byte = out_port[15:8];
      REG_CFG0: rd_byte = cfg_port[7:0];
      REG_CFG1: rd_byte = cfg_port[15:8];
      default:  rd_byte = 8'h00;
    endcase
  end

  // Protocol next-state and register-file updates; START/STOP override any state
  always_comb begin
    state_nx  = state;
    bit_nx    = bit_cnt;
    phase_nx  = phase;
    rw_nx     = rw;
    sh_nx     = sh;
    tx_nx     = tx;
    ptr_nx    = ptr;
    out_nx    = out_port;
    cfg_nx    = cfg_port;
    wr_nx     = wr_flag;
    busy_nx   = busy;
    oe_nx     = sda_oe_n;
    update_nx = 1'b0;
    if (start) begin
      state_nx = ADDR;
      bit_nx   = 3'd0;
      phase_nx = 1'b0;
      busy_nx  = 1'b1;
      oe_nx    = 1'b1;
    end else if (stop) begin
      state_nx  = IDLE;
      busy_nx   = 1'b0;
      oe_nx     = 1'b1;
      update_nx = wr_flag;
      wr_nx     = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_nx  = rx[6:0];
          bit_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx[7:1] == DEV_ADDR) begin
              state_nx = ADDR_ACK;
              rw_nx    = rx[0];
              phase_nx = 1'b0;
            end else begin
              state_nx = IDLE;
              busy_nx  = 1'b0;
            end
          end
        end
        // First SCL fall drives ACK low, second releases it and moves on
        ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
          if (!phase) begin
            oe_nx    = 1'b0;
            phase_nx = 1'b1;
          end else begin
            phase_nx = 1'b0;
            bit_nx   = 3'd0;
            oe_nx    = 1'b1;
            if (state == ADDR_ACK && rw) begin
              tx_nx    = rd_byte[6:0];
              oe_nx    = rd_byte[7];
              state_nx = RDATA;
            end else if (state == ADDR_ACK) begin
              state_nx = REG;
            end else begin
              state_nx = WDATA;
            end
          end
        end
        REG: if (scl_rise) begin
          sh_nx  = rx[6:0];
          bit_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_nx   = rx;
            state_nx = REG_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          sh_nx  = rx[6:0];
          bit_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (ptr)
              REG_OUT0: begin out_nx[7:0]  = rx; wr_nx = 1'b1; end
              REG_OUT1: begin out_nx[15:8] = rx; wr_nx = 1'b1; end
              REG_CFG0: begin cfg_nx[7:0]  = rx; wr_nx = 1'b1; end
              REG_CFG1: begin cfg_nx[15:8] = rx; wr_nx = 1'b1; end
              default: ;
            endcase
            ptr_nx   = {ptr[7:1], ~ptr[0]};
            state_nx = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            oe_nx = tx[6];
            tx_nx = {tx[5:0], 1'b0};
          end
          if (scl_rise) begin
            bit_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nx = RDATA_ACK;
              phase_nx = 1'b0;
            end
          end
        end
        // Release for the initiator's ACK, then reload on ACK or drop out on NACK
        RDATA_ACK: begin
          if (scl_fall && !phase) begin
            oe_nx    = 1'b1;
            phase_nx = 1'b1;
          end else if (scl_fall) begin
            tx_nx    = rd_byte[6:0];
            oe_nx    = rd_byte[7];
            bit_nx   = 3'd0;
            phase_nx = 1'b0;
            state_nx = RDATA;
          end
          if (scl_rise) begin
            if (!sda_f) ptr_nx = {ptr[7:1], ~ptr[0]};
            else        state_nx = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Control, pointer and register-file state
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      phase    <= 1'b0;
      rw       <= 1'b0;
      ptr      <= 8'h00;
      out_port <= OUT_RST;
      cfg_port <= CFG_RST;
      wr_flag  <= 1'b0;
      busy     <= 1'b0;
      sda_oe_n <= 1'b1;
      update   <= 1'b0;
    end else begin
      bit_cnt  <= bit_nx;
      phase    <= phase_nx;
      rw       <= rw_nx;
      ptr      <= ptr_nx;
      out_port <= out_nx;
      cfg_port <= cfg_nx;
      wr_flag  <= wr_nx;
      busy     <= busy_nx;
      sda_oe_n <= oe_nx;
      update   <= update_nx;
    end
  end

  // Shift registers carry data only and need no reset
  always_ff @(posedge clk) begin
    sh <= sh_nx;
    tx <= tx_nx;
  end

endmodule

// File: tb/tb_i2c_ioexp_target.sv
// Directed plus randomized bench: bit-banged I2C initiator against a register-map model.
module tb_i2c_ioexp_target;
  import i2c_pkg::*;

  localparam int          H       = 20;
  localparam int          FILT    = 4;
  localparam logic [15:0] OUT_RST = 16'h0000;
  localparam logic [15:0] CFG_RST = 16'hFFFF;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        sda_oe_n, update, busy;
  logic [15:0] in_port = 16'h0000;
  logic [15:0] out_port, cfg_port;
  int          n_chk = 0;
  int          n_pass = 0;
  int          upd_cnt = 0;
  logic [7:0]  ref_ptr = 8'h00;
  logic [15:0] ref_out = OUT_RST;
  logic [15:0] ref_cfg = CFG_RST;

  assign sda_line = m_sda & sda_oe_n;

  always #5 clk = ~clk;

  always @(posedge clk) if (update === 1'b1) upd_cnt <= upd_cnt + 1;

  i2c_ioexp_target dut (
    .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(sda_line),
    .sda_oe_n(sda_oe_n), .in_port(in_port), .out_port(out_port),
    .cfg_port(cfg_port), .update(update), .busy(busy)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register map as seen from the bus
  function automatic logic [7:0] ref_rd(input logic [7:0] p);
    case (p)
      8'h00:   return in_port[7:0];
      8'h01:   return in_port[15:8];
      8'h02:   return ref_out[7:0];
      8'h03:   return ref_out[15:8];
      8'h06:   return ref_cfg[7:0];
      8'h07:   return ref_cfg[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic ref_wr(input logic [7:0] d, output logic hit);
    hit = 1'b1;
    case (ref_ptr)
      8'h02:   ref_out[7:0]  = d;
      8'h03:   ref_out[15:8] = d;
      8'h06:   ref_cfg[7:0]  = d;
      8'h07:   ref_cfg[15:8] = d;
      default: hit = 1'b0;
    endcase
    ref_ptr = {ref_ptr[7:1], ~ref_ptr[0]};
  endtask

  function automatic logic [7:0] rand_ptr();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h03;
      4:       return 8'h06;
      5:       return 8'h07;
      default: return 8'($urandom_range(8, 255));
    endcase
  endfunction

  // One SCL period starting and ending with SCL low; optional low glitch early in the high phase
  task automatic clk_bit(input logic b, input int glitch, output logic s);
    tick(H / 2);
    m_sda = b;
    tick(H / 2);
    m_scl = 1'b1;
    tick(4);
    if (glitch > 0) begin
      m_scl = 1'b0;
      tick(glitch);
      m_scl = 1'b1;
    end
    tick(H / 2 - 4);
    s = sda_line;
    tick(H / 2);
    m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(H / 2);
    m_scl = 1'b1;
    tick(H);
    m_sda = 1'b0;
    tick(H);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(H / 2);
    m_scl = 1'b1;
    tick(H);
    m_sda = 1'b1;
    tick(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int glitch);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == 7) ? glitch : 0, s);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch, output logic ack);
    logic s;
    send_bits(b, glitch);
    clk_bit(1'b1, 0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 0, s);
      b[i] = s;
    end
    clk_bit(nack, 0, s);
  endtask

  // Write transaction; a glitch of at least FILT cycles adds a clock, duplicating the MSB
  task automatic wr_txn(input string tag, input logic [7:0] p, input int nb,
                        input logic [31:0] data, input int g, input logic exp_ack);
    logic a, all_ack, any_wr, h;
    logic [7:0] d;
    int u0;
    u0 = upd_cnt;
    all_ack = 1'b1;
    any_wr = 1'b0;
    i2c_start();
    write_byte(8'h40, 0, a); all_ack &= a;
    write_byte(p, 0, a);     all_ack &= a;
    ref_ptr = p;
    for (int i = 0; i < nb; i++) begin
      d = data[8*i +: 8];
      write_byte(d, (i == 0) ? g : 0, a);
      all_ack &= a;
      if (i == 0 && g >= FILT) d = {d[7], d[7:1]};
      ref_wr(d, h);
      any_wr |= h;
    end
    i2c_stop();
    tick(4);
    chk({tag, "_ack"}, 32'(all_ack), 32'(exp_ack));
    chk({tag, "_out"}, 32'(out_port), 32'(ref_out));
    chk({tag, "_cfg"}, 32'(cfg_port), 32'(ref_cfg));
    chk({tag, "_upd"}, 32'(upd_cnt - u0), any_wr ? 32'd1 : 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Pointer write, repeated START, two-byte read (ACK then NACK)
  task automatic rd_txn(input string tag, input logic [7:0] p);
    logic a, all_ack;
    logic [7:0] b0, b1, e0, e1;
    int u0;
    u0 = upd_cnt;
    all_ack = 1'b1;
    i2c_start();
    write_byte(8'h40, 0, a); all_ack &= a;
    write_byte(p, 0, a);     all_ack &= a;
    i2c_start();
    write_byte(8'h41, 0, a); all_ack &= a;
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    ref_ptr = p;
    e0 = ref_rd(ref_ptr);
    ref_ptr = {ref_ptr[7:1], ~ref_ptr[0]};
    e1 = ref_rd(ref_ptr);
    chk({tag, "_ack"}, 32'(all_ack), 32'd1);
    chk({tag, "_b0"}, 32'(b0), 32'(e0));
    chk({tag, "_b1"}, 32'(b1), 32'(e1));
    chk({tag, "_rel"}, 32'(sda_oe_n), 32'd1);
    chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
    i2c_stop();
    tick(4);
    chk({tag, "_upd"}, 32'(upd_cnt - u0), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic a, all_ack, h;
    int u0, w;
    string tg;

    tick(5);
    reset = 1'b0;
    tick(2);
    chk("rst_oe", 32'(sda_oe_n), 32'd1);
    chk("rst_out", 32'(out_port), 32'(OUT_RST));
    chk("rst_cfg", 32'(cfg_port), 32'(CFG_RST));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_upd", 32'(update), 32'd0);

    // Basic out_port write, visible before STOP
    u0 = upd_cnt;
    all_ack = 1'b1;
    i2c_start();
    chk("t1_busy_start", 32'(busy), 32'd1);
    write_byte(8'h40, 0, a); all_ack &= a;
    write_byte(8'h02, 0, a); all_ack &= a;
    ref_ptr = 8'h02;
    write_byte(8'h34, 0, a); all_ack &= a; ref_wr(8'h34, h);
    write_byte(8'h12, 0, a); all_ack &= a; ref_wr(8'h12, h);
    chk("t1_ack", 32'(all_ack), 32'd1);
    chk("t1_out_pre_stop", 32'(out_port), 32'(ref_out));
    chk("t1_upd_pre_stop", 32'(upd_cnt - u0), 32'd0);
    i2c_stop();
    tick(4);
    chk("t1_upd", 32'(upd_cnt - u0), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // Wrong address: no ACK, busy drops immediately
    u0 = upd_cnt;
    i2c_start();
    write_byte(8'h42, 0, a);
    chk("t2_nack", 32'(a), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);
    i2c_stop();
    tick(4);
    chk("t2_out", 32'(out_port), 32'(ref_out));
    chk("t2_upd", 32'(upd_cnt - u0), 32'd0);

    // Pair wrap on the config registers
    wr_txn("t3", 8'h06, 3, 32'h00AA_0000, 0, 1'b1);

    // Read in_port through repeated START
    in_port = 16'hBEEF;
    rd_txn("t4", 8'h00);

    // SCL glitches inside a data bit: short one filtered, long one counted as a clock
    wr_txn("t5a", 8'h02, 1, 32'h0000_00C5, 2, 1'b1);
    wr_txn("t5b", 8'h02, 1, 32'h0000_005A, 6, 1'b0);

    // Randomized writes and reads against the model
    for (int k = 0; k < 4; k++) begin
      tg = $sformatf("rw%0d", k);
      wr_txn(tg, rand_ptr(), int'($urandom_range(1, 3)), $urandom, 0, 1'b1);
      in_port = 16'($urandom);
      tg = $sformatf("rr%0d", k);
      rd_txn(tg, rand_ptr());
    end

    // Reset while the target holds the address ACK low
    i2c_start();
    send_bits(8'h40, 0);
    w = 0;
    while (sda_oe_n !== 1'b0 && w < 50) begin
      tick(1);
      w++;
    end
    chk("t6_ack_low", 32'(sda_oe_n), 32'd0);
    reset = 1'b1;
    tick(1);
    chk("t6_oe_rel", 32'(sda_oe_n), 32'd1);
    chk("t6_out_rst", 32'(out_port), 32'(OUT_RST));
    chk("t6_cfg_rst", 32'(cfg_port), 32'(CFG_RST));
    chk("t6_busy_rst", 32'(busy), 32'd0);
    reset = 1'b0;
    ref_out = OUT_RST;
    ref_cfg = CFG_RST;
    ref_ptr = 8'h00;
    m_sda = 1'b1;
    tick(H);
    m_scl = 1'b1;
    tick(H);
    wr_txn("t6", 8'h03, 1, 32'h0000_005A, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
